// File: rtl/sram_arbiter.sv
// Purpose : two-port arbiter and cycle sequencer for the shared 1Mx16 async SRAM.
// Latency : req sampled in IDLE -> ready pulse WAIT_CYCLES+2 cycles later; one access per WAIT_CYCLES+3.
// Backpressure: non-preemptive; a losing or late request simply waits, held high, for the next IDLE.
//
// Ports:
//   Clk, Reset          system clock, synchronous active-high reset
//   req/we/addr/wdata/be 0|1  requester side (port 0 = CPU, port 1 = loader/DMA)
//   rdata, ready0/1     registered read data (shared) and one-cycle completion pulses
//   Mem_CE/UB/LB/OE/WE  active-low SRAM strobes; ADDR address
//   Data_to_SRAM, Data_drive, Data_from_SRAM   pad data path and tristate enable
//
// Optional build macro: ARB_CPU_PRIORITY_EN -- port 0 wins every tie (fixed priority).
// Without it, ties alternate round-robin using last_grant.

module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2  // OE/WE low time per access, 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  output logic [15:0] rdata,
  output logic        ready0,
  output logic        ready1,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_drive,
  input  logic [15:0] Data_from_SRAM
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  // Also identifies the port currently being served, since it updates on every grant.
  logic        last_grant;

  logic        pick1;
  logic        sel_we;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be;
  logic [1:0]  be_eff;

  always_comb begin
    pick1 = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
    pick1 = req1 & ~req0;
`else
    // On a tie, port 1 wins only if port 0 had the previous grant.
    pick1 = req1 & (~req0 | ~last_grant);
`endif
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
    sel_be    = pick1 ? be1    : be0;
    // No byte lanes selected means a full-word access.
    be_eff    = (sel_be == 2'b00) ? 2'b11 : sel_be;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      we_q         <= 1'b0;
      last_grant   <= 1'b1;
      Mem_CE       <= 1'b1;
      Mem_UB       <= 1'b1;
      Mem_LB       <= 1'b1;
      Mem_OE       <= 1'b1;
      Mem_WE       <= 1'b1;
      Data_drive   <= 1'b0;
      ready0       <= 1'b0;
      ready1       <= 1'b0;
      rdata        <= 16'h0000;
      ADDR         <= 20'h00000;
      Data_to_SRAM <= 16'h0000;
    end else begin
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            // Grant edge: the SETUP-cycle pin values are registered here.
            last_grant   <= pick1;
            we_q         <= sel_we;
            ADDR         <= sel_addr;
            Data_to_SRAM <= sel_wdata;
            Mem_CE       <= 1'b0;
            Mem_UB       <= ~be_eff[1];
            Mem_LB       <= ~be_eff[0];
            Data_drive   <= sel_we;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          wait_cnt <= WAIT_LOAD;
          Mem_OE   <= sel_strobe_off(~we_q);
          Mem_WE   <= sel_strobe_off(we_q);
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            Mem_CE <= 1'b1;
            Mem_UB <= 1'b1;
            Mem_LB <= 1'b1;
            Mem_OE <= 1'b1;
            Mem_WE <= 1'b1;
            if (!we_q) begin
              rdata <= Data_from_SRAM;
            end
            ready0 <= ~last_grant;
            ready1 <= last_grant;
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          // Write data stays driven one cycle past the WE rising edge for hold time.
          Data_drive <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Active-low strobe value: low when the strobe is wanted.
  function automatic logic sel_strobe_off(input logic want);
    return ~want;
  endfunction

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose : directed self-checking bench for sram_arbiter (default and WAIT_CYCLES=1 builds).
// Latency : n/a (bench).
// Backpressure: n/a (bench).

module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic [15:0] rdata;
  logic        ready0, ready1;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        Data_drive;
  logic [15:0] Data_from_SRAM;

  // Second instance with WAIT_CYCLES=1, read-only use.
  logic        b_req0;
  logic [19:0] b_addr0;
  logic [15:0] b_rdata;
  logic        b_ready0, b_ready1;
  logic        b_ce, b_ub, b_lb, b_oe, b_we;
  logic [19:0] b_addr_o;
  logic [15:0] b_dout;
  logic        b_drive;
  logic [15:0] b_din;

  int checks;
  int failures;

  // SRAM model, 1M x 16.
  logic [15:0] mem [0:(1<<20)-1];
  logic        pl_en;
  logic [19:0] pl_addr;
  logic [15:0] pl_data;

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1),
    .rdata(rdata), .ready0(ready0), .ready1(ready1),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_drive(Data_drive),
    .Data_from_SRAM(Data_from_SRAM)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .Clk(Clk), .Reset(Reset),
    .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(b_addr0), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
    .be0(2'b11), .be1(2'b11),
    .rdata(b_rdata), .ready0(b_ready0), .ready1(b_ready1),
    .Mem_CE(b_ce), .Mem_UB(b_ub), .Mem_LB(b_lb), .Mem_OE(b_oe), .Mem_WE(b_we),
    .ADDR(b_addr_o), .Data_to_SRAM(b_dout), .Data_drive(b_drive),
    .Data_from_SRAM(b_din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? mem[ADDR] : 16'h0000;
  assign b_din          = (!b_ce && !b_oe) ? mem[b_addr_o] : 16'h0000;

  // Writes commit per enabled byte lane on each clock edge while WE and CE are low.
  always @(posedge Clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!Mem_CE && !Mem_WE && Data_drive) begin
      if (!Mem_UB) mem[ADDR][15:8] <= Data_to_SRAM[15:8];
      if (!Mem_LB) mem[ADDR][7:0]  <= Data_to_SRAM[7:0];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} !== 5'b11111) begin
        failures++;
        $display("FAIL reset_strobes k=%0d got=%b exp=11111", k, {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE});
      end
      checks++;
      if ({Data_drive, ready0, ready1, rdata, ADDR, Data_to_SRAM} !== 55'h0) begin
        failures++;
        $display("FAIL reset_data k=%0d drive=%b rdy=%b%b rdata=%h addr=%h dout=%h exp all zero",
                 k, Data_drive, ready0, ready1, rdata, ADDR, Data_to_SRAM);
      end
      checks++;
      if ({b_ce, b_oe, b_we, b_ready0, b_rdata} !== {3'b111, 1'b0, 16'h0}) begin
        failures++;
        $display("FAIL reset_w1 k=%0d ce=%b oe=%b we=%b rdy=%b rdata=%h", k, b_ce, b_oe, b_we, b_ready0, b_rdata);
      end
      Reset = 1'b0;
      tick();
    end
  endtask

  task automatic test_read_port0();
    preload(20'h00123, 16'hBEEF);
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00123; be0 = 2'b11;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) req0 = 1'b0;
      checks++;
      if (Mem_OE !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL read_oe c=%0d got=%b", c, Mem_OE);
      end
      checks++;
      if (Mem_WE !== 1'b1) begin
        failures++;
        $display("FAIL read_we c=%0d got=%b exp=1", c, Mem_WE);
      end
      checks++;
      if ({ready0, ready1} !== ((c == 4) ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL read_ready c=%0d got=%b%b", c, ready0, ready1);
      end
      if (c == 1) begin
        checks++;
        if ({Mem_CE, ADDR} !== {1'b0, 20'h00123}) begin
          failures++;
          $display("FAIL read_setup ce=%b addr=%h exp ce=0 addr=00123", Mem_CE, ADDR);
        end
      end
      if (c == 4) begin
        checks++;
        if (rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL read_rdata got=%h exp=beef", rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_byte_write_port1();
    preload(20'hFFFFF, 16'hABCD);
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'hFFFFF; wdata1 = 16'h1234; be1 = 2'b01;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) req1 = 1'b0;
      checks++;
      if ({Mem_UB, Mem_LB} !== ((c >= 1 && c <= 3) ? 2'b10 : 2'b11)) begin
        failures++;
        $display("FAIL wr_lanes c=%0d got ub/lb=%b%b", c, Mem_UB, Mem_LB);
      end
      checks++;
      if ({Mem_WE, Mem_OE} !== ((c == 2 || c == 3) ? 2'b01 : 2'b11)) begin
        failures++;
        $display("FAIL wr_we c=%0d got we/oe=%b%b", c, Mem_WE, Mem_OE);
      end
      checks++;
      if (Data_drive !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL wr_drive c=%0d got=%b", c, Data_drive);
      end
      checks++;
      if ({ready0, ready1} !== ((c == 4) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL wr_ready c=%0d got=%b%b", c, ready0, ready1);
      end
      tick();
    end
    checks++;
    if (mem[20'hFFFFF] !== 16'hAB34) begin
      failures++;
      $display("FAIL wr_mem got=%h exp=ab34", mem[20'hFFFFF]);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_rdata_kept got=%h exp=beef", rdata);
    end
  endtask

  task automatic test_tie();
    logic exp_port;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010; be0 = 2'b11;
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00020; be1 = 2'b11;
    for (int c = 0; c < 20; c++) begin
`ifdef ARB_CPU_PRIORITY_EN
      exp_port = 1'b0;
`else
      exp_port = ((c / 5) % 2) == 1;
`endif
      if (c % 5 == 1) begin
        checks++;
        if (ADDR !== (exp_port ? 20'h00020 : 20'h00010)) begin
          failures++;
          $display("FAIL tie_grant c=%0d addr=%h exp_port=%0d", c, ADDR, exp_port);
        end
      end
      checks++;
      if ({ready1, ready0} !== ((c % 5 == 4) ? (exp_port ? 2'b10 : 2'b01) : 2'b00)) begin
        failures++;
        $display("FAIL tie_ready c=%0d got r0=%b r1=%b exp_port=%0d", c, ready0, ready1, exp_port);
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_late_arrival();
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00123; be0 = 2'b00;
    we1 = 1'b0; addr1 = 20'h00777; be1 = 2'b11;
    for (int c = 0; c < 12; c++) begin
      if (c == 1)  req0 = 1'b0;
      if (c == 2)  req1 = 1'b1;
      if (c == 10) req1 = 1'b0;
      if (c == 1 || c == 6) begin
        checks++;
        if ({ADDR, Mem_UB, Mem_LB} !== {(c == 1) ? 20'h00123 : 20'h00777, 2'b00}) begin
          failures++;
          $display("FAIL late_setup c=%0d addr=%h ub/lb=%b%b", c, ADDR, Mem_UB, Mem_LB);
        end
      end
      checks++;
      if ({ready0, ready1} !== ((c == 4) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL late_ready c=%0d got r0=%b r1=%b", c, ready0, ready1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    preload(20'h00055, 16'h5A5A);
    req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00055; wdata0 = 16'hC3C3; be0 = 2'b01;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) req0 = 1'b0;
      if (c == 2) Reset = 1'b1;
      if (c == 3) Reset = 1'b0;
      if (c == 3) begin
        checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_drive} !== 6'b111110) begin
          failures++;
          $display("FAIL rst_mid_strobes got=%b exp=111110",
                   {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_drive});
        end
      end
      if (c >= 2) begin
        checks++;
        if ({ready0, ready1} !== 2'b00) begin
          failures++;
          $display("FAIL rst_mid_ready c=%0d got=%b%b exp=00", c, ready0, ready1);
        end
      end
      tick();
    end
    checks++;
    if (mem[20'h00055][15:8] !== 8'h5A) begin
      failures++;
      $display("FAIL rst_mid_mem upper=%h exp=5a", mem[20'h00055][15:8]);
    end
  endtask

  task automatic test_wait1_read();
    preload(20'h00321, 16'h0F1E);
    b_req0 = 1'b1; b_addr0 = 20'h00321;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) b_req0 = 1'b0;
      checks++;
      if (b_oe !== ((c == 2) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL w1_oe c=%0d got=%b", c, b_oe);
      end
      checks++;
      if (b_ready0 !== ((c == 3) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL w1_ready c=%0d got=%b", c, b_ready0);
      end
      if (c == 3) begin
        checks++;
        if (b_rdata !== 16'h0F1E) begin
          failures++;
          $display("FAIL w1_rdata got=%h exp=0f1e", b_rdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 20'h0; addr1 = 20'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    be0 = 2'b11; be1 = 2'b11;
    b_req0 = 1'b0; b_addr0 = 20'h0;
    pl_en = 1'b0; pl_addr = 20'h0; pl_data = 16'h0;

    test_reset();
    test_read_port0();
    test_byte_write_port1();
    test_tie();
    test_late_arrival();
    test_reset_mid_access();
    test_wait1_read();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
